// File: rtl/instr_mem_loader.sv
// Byte-stream instruction memory loader: packs little-endian bytes into words,
// writes them from address 0, then releases the core reset. Optional macro: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    word_count,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int NB  = INSTR_WIDTH / 8;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [BW-1:0]  LAST_BYTE = BW'(NB - 1);
  localparam logic [AW1-1:0] DEPTH_C   = AW1'(DEPTH);
  localparam logic [AW1-1:0] ONE_A     = AW1'(1);
  localparam logic [BW-1:0]  ONE_B     = BW'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [BW-1:0]          bidx_q, bidx_d;
  logic [AW1-1:0]         addr_q, addr_d;
  logic [AW1-1:0]         wcnt_q, wcnt_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   crst_q, crst_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bidx_q  <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    done_d  = done_q;
    err_d   = err_q;
    crst_d  = crst_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DONE;
          if (word_count == '0) begin
            done_d = 1'b1;
            err_d  = 1'b0;
            crst_d = 1'b1;
          end else if (word_count > DEPTH_C) begin
            done_d = 1'b0;
            err_d  = 1'b1;
            crst_d = 1'b0;
          end else begin
            state_d = S_RECV;
            done_d  = 1'b0;
            err_d   = 1'b0;
            crst_d  = 1'b0;
            bidx_d  = '0;
            addr_d  = '0;
            wcnt_d  = word_count;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
      end
      S_RECV: begin
        if (in_valid) begin
          word_d[8*bidx_q +: 8] = in_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (bidx_q == LAST_BYTE) begin
            bidx_d  = '0;
            state_d = S_WRITE;
          end else begin
            bidx_d = bidx_q + ONE_B;
          end
        end
      end
      S_WRITE: begin
        // Address parks on the last written word so mem_waddr stays within DEPTH-1.
        if (addr_q + ONE_A == wcnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          crst_d  = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + ONE_A;
          state_d = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (in_valid) begin
          state_d = S_DONE;
          if (in_data == csum_q) begin
            done_d = 1'b1;
            crst_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign busy     = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
  assign in_ready = (state_q == S_RECV);
  assign busy     = (state_q == S_RECV) || (state_q == S_WRITE);
`endif
  assign mem_we     = (state_q == S_WRITE);
  assign mem_waddr  = addr_q[ADDR_WIDTH-1:0];
  assign mem_wdata  = word_q;
  assign core_rst_n = crst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Streams a program image into the core's instruction memory over a byte-wide valid/ready interface, replacing file-based preloading. Assembles little-endian bytes into INSTR_WIDTH words and issues one write per word starting at address 0. Holds the core in reset until the load completes cleanly, then releases it. Sits between a host/bench byte source and the instruction memory write port, beside riscv_top.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width (matches rom_addr)
INSTR_WIDTH, 32, instruction word width; must be a multiple of 8
DEPTH, 256, number of instruction memory words; must be <= 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
word_count  input  ADDR_WIDTH+1  number of words to load; sampled with start
in_valid  input  1  byte source has a valid byte
in_data  input  8  byte payload
in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_waddr  output  ADDR_WIDTH  word write address
mem_wdata  output  INSTR_WIDTH  assembled instruction word
core_rst_n  output  1  active-low reset to the core
busy  output  1  load in progress
done  output  1  last load completed without error; held until the next start
err  output  1  last load failed; held until the next start

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, FSM=IDLE.
- States: IDLE, RECV, WRITE, CHECK (only with the optional feature), DONE.
- IDLE/DONE + start:
  - word_count==0: go to DONE with done=1 and core_rst_n=1. No writes.
  - word_count>DEPTH: go to DONE with err=1 and core_rst_n=0. No writes.
  - Otherwise: go to RECV. Set busy=1, core_rst_n=0, clear done/err, clear the byte index and word address.
- RECV:
  - in_ready=1.
  - Each transfer places in_data at byte lane [8*k+7:8*k], where k is the byte index (little-endian).
  - After the transfer with k==INSTR_WIDTH/8-1, go to WRITE.
  - in_valid low stalls indefinitely with no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_waddr=current address, mem_wdata=assembled word.
  - Address increments after the write.
  - If the written word was word word_count-1, go to DONE (or CHECK). Otherwise return to RECV.
  - Cost: 1 bubble cycle per word.
- DONE:
  - busy=0, in_ready=0.
  - done=1 and core_rst_n=1 on success.
  - core_rst_n deasserts in the same cycle done rises, and no earlier than one cycle after the last mem_we.
- start while busy is ignored. Bytes presented outside RECV/CHECK are not consumed.
- A new start from DONE re-asserts core_rst_n=0 the cycle after start is sampled.
- mem_waddr never exceeds DEPTH-1. The address counter is ADDR_WIDTH+1 wide internally to avoid wrap when DEPTH==2**ADDR_WIDTH.
- rst_n low mid-load: everything returns to reset values immediately; the partial image is abandoned and the core is held in reset.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After the last WRITE, the FSM enters CHECK with in_ready=1 and consumes exactly one extra byte.
  - Expected value is the XOR of all image bytes.
  - Match: DONE with done=1 and core_rst_n=1.
  - Mismatch: DONE with err=1 and core_rst_n held 0.
  - word_count==0 skips CHECK.
- Undefined: no CHECK state, no checksum byte, and err is raised only for word_count>DEPTH.

Test Plan:
- Load 2 words, bytes 13,05,10,00,B7,02,00,00 (gaps in in_valid) -> mem_we at addr 0 data 0x00100513 and addr 1 data 0x000002B7. done=1, core_rst_n=1 only after the second write.
- start with word_count=0 -> no mem_we; done=1 and core_rst_n=1 within 2 cycles.
- start with word_count=257 (DEPTH=256) -> err=1, core_rst_n=0, no mem_we, in_ready never high.
- Load DEPTH=256 words -> last write at addr 0xFF with no address wrap; second start during the load is ignored (word count unchanged).
- Assert rst_n=0 after 5 bytes of a 4-word load -> all outputs return to reset values. A fresh 1-word load then writes addr 0.
- With LOADER_CHECKSUM_EN, load 1 word 0x00000013 followed by checksum byte 0x13 -> done=1. Repeat with checksum byte 0x12 -> err=1, core_rst_n=0.
